// File: rtl/seven_seg_pkg.sv
// Purpose: shared glyph table, hex decode and output-polarity helpers for the seven-segment driver family.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
//
// Contents:
//   seg_t           7-bit segment vector ordered {g,f,e,d,c,b,a}
//   GLYPH_0..F      active-high glyph codes (lowercase b and d)
//   hex_to_seg()    4-bit nibble -> active-high glyph
//   seg_polarity()  optional inversion of a segment vector for active-low boards
//   bit_polarity()  optional inversion of a single control bit
package seven_seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h00;

    localparam seg_t GLYPH_0 = 7'h3F;
    localparam seg_t GLYPH_1 = 7'h06;
    localparam seg_t GLYPH_2 = 7'h5B;
    localparam seg_t GLYPH_3 = 7'h4F;
    localparam seg_t GLYPH_4 = 7'h66;
    localparam seg_t GLYPH_5 = 7'h6D;
    localparam seg_t GLYPH_6 = 7'h7D;
    localparam seg_t GLYPH_7 = 7'h07;
    localparam seg_t GLYPH_8 = 7'h7F;
    localparam seg_t GLYPH_9 = 7'h6F;
    localparam seg_t GLYPH_A = 7'h77;
    localparam seg_t GLYPH_B = 7'h7C;
    localparam seg_t GLYPH_C = 7'h39;
    localparam seg_t GLYPH_D = 7'h5E;
    localparam seg_t GLYPH_E = 7'h79;
    localparam seg_t GLYPH_F = 7'h71;

    function automatic seg_t hex_to_seg(input logic [3:0] nib);
        seg_t s;
        s = SEG_BLANK;
        case (nib)
            4'h0: s = GLYPH_0;
            4'h1: s = GLYPH_1;
            4'h2: s = GLYPH_2;
            4'h3: s = GLYPH_3;
            4'h4: s = GLYPH_4;
            4'h5: s = GLYPH_5;
            4'h6: s = GLYPH_6;
            4'h7: s = GLYPH_7;
            4'h8: s = GLYPH_8;
            4'h9: s = GLYPH_9;
            4'hA: s = GLYPH_A;
            4'hB: s = GLYPH_B;
            4'hC: s = GLYPH_C;
            4'hD: s = GLYPH_D;
            4'hE: s = GLYPH_E;
            4'hF: s = GLYPH_F;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic seg_t seg_polarity(input seg_t s, input logic active_low);
        return active_low ? ~s : s;
    endfunction

    function automatic logic bit_polarity(input logic b, input logic active_low);
        return active_low ? ~b : b;
    endfunction

endpackage

// File: rtl/seven_segment_decoder.sv
// Purpose: combinational hex-to-glyph decoder with a blank override, always active-high.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
//
// Ports:
//   digit   4-bit hex nibble to display
//   blank   1 forces every segment off (used for leading-zero blanking)
//   seg_ah  active-high segments {g,f,e,d,c,b,a}
module seven_segment_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output seg_t       seg_ah
);

    always_comb begin
        seg_ah = blank ? SEG_BLANK : hex_to_seg(digit);
    end

endmodule

// File: rtl/multiplexed_seven_segment_driver.sv
// Purpose: time-multiplexed, double-buffered driver for NUM_DIGITS seven-segment digits on a shared segment bus.
// Latency: outputs are registered one cycle after the digit index they reflect; a load shows from the next frame.
// Backpressure: none; load is accepted every cycle and the scan free-runs.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   value_in, dp_in     packed hex digits / decimal points, captured into the pending buffer on load
//   digit_en            per-digit anode enable (slot still consumed when disabled)
//   lzb_en, blink_en    leading-zero blanking and whole-display blink
//   seg, dp, anode      registered display drive, polarity set by ACTIVE_LOW
//   frame_done          one-cycle pulse in the cycle after the scan wraps to digit 0
module multiplexed_seven_segment_driver
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 64,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lzb_en,
    input  logic                    blink_en,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frame_done
);

    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SLOT_W  = $clog2(REFRESH_DIV);
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
    localparam logic               INV        = (ACTIVE_LOW != 0);

    // ------------------------------------------------------------------
    // Scan and blink state
    // ------------------------------------------------------------------
    logic [SLOT_W-1:0]  slot_cnt;
    logic [IDX_W-1:0]   digit_idx;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_off;   // 0 = visible half-period, the reset phase

    logic slot_last;
    logic frame_wrap;

    assign slot_last  = (slot_cnt == SLOT_LAST);
    assign frame_wrap = slot_last && (digit_idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt   <= '0;
            digit_idx  <= '0;
            blink_cnt  <= '0;
            blink_off  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_wrap;

            if (slot_last) begin
                slot_cnt  <= '0;
                digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
            end else begin
                slot_cnt <= slot_cnt + SLOT_W'(1);
            end

            // The blink counter keeps running even with blink_en low so that
            // enabling blink mid-run lands on a consistent phase.
            if (frame_wrap) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    blink_off <= ~blink_off;
                end else begin
                    blink_cnt <= blink_cnt + BLINK_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Double buffer: pending is written on load, display copies pending
    // only on the wrap edge so a frame never mixes old and new digits.
    // A load on the wrap cycle lands in pending after display has already
    // sampled the old contents, so it shows one frame later.
    // ------------------------------------------------------------------
    logic [4*NUM_DIGITS-1:0] pend_val;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [4*NUM_DIGITS-1:0] disp_val;
    logic [NUM_DIGITS-1:0]   disp_dp;

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_val <= '0;
            pend_dp  <= '0;
            disp_val <= '0;
            disp_dp  <= '0;
        end else begin
            if (load) begin
                pend_val <= value_in;
                pend_dp  <= dp_in;
            end
            if (frame_wrap) begin
                disp_val <= pend_val;
                disp_dp  <= pend_dp;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan mux, leading-zero mask and anode gating
    // ------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  zero_run;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_blank;
    logic [NUM_DIGITS-1:0] anode_ah;
    seg_t                  dec_seg;

    // A digit is blanked when it and everything more significant is zero;
    // walking from the top digit down accumulates that condition.
    always_comb begin
        lz_mask  = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run   = zero_run & (disp_val[4*i +: 4] == 4'h0);
            lz_mask[i] = lzb_en & zero_run & (i != 0);
        end
    end

    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        anode_ah  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx == IDX_W'(i)) begin
                cur_nib     = disp_val[4*i +: 4];
                cur_dp      = disp_dp[i];
                cur_blank   = lz_mask[i];
                anode_ah[i] = 1'b1;
            end
        end
        // Disabled digits and the blink-off phase only gate the anodes;
        // the slot is still consumed so scan timing never changes.
        anode_ah = anode_ah & digit_en & {NUM_DIGITS{~(blink_en & blink_off)}};
    end

    seven_segment_decoder u_decoder (
        .digit  (cur_nib),
        .blank  (cur_blank),
        .seg_ah (dec_seg)
    );

    // ------------------------------------------------------------------
    // Registered outputs with board polarity applied
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            seg   <= seg_polarity(SEG_BLANK, INV);
            dp    <= bit_polarity(1'b0, INV);
            anode <= {NUM_DIGITS{INV}};
        end else begin
            seg   <= seg_polarity(dec_seg, INV);
            dp    <= bit_polarity(cur_dp, INV);
            anode <= anode_ah ^ {NUM_DIGITS{INV}};
        end
    end

endmodule

// File: tb/tb_multiplexed_seven_segment_driver.sv
// Purpose: directed self-checking bench for the multiplexed seven-segment driver (4 digits, 4-cycle slots, 2-frame blink, active-low).
// Latency: cycle k after reset release shows digit ((k-1)/4)%4; frame_done is high when k is a multiple of 16.
// Backpressure: none.
module tb_multiplexed_seven_segment_driver;

    localparam logic [6:0] L0     = 7'b1000000;
    localparam logic [6:0] L1     = 7'b1111001;
    localparam logic [6:0] L3     = 7'b0110000;
    localparam logic [6:0] L5     = 7'b0010010;
    localparam logic [6:0] L9     = 7'b0010000;
    localparam logic [6:0] LC     = 7'b1000110;
    localparam logic [6:0] LBLANK = 7'b1111111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  digit_en = 4'b1111;
    logic        lzb_en = 1'b0;
    logic        blink_en = 1'b0;
    logic        load = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  anode;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multiplexed_seven_segment_driver #(
        .NUM_DIGITS   (4),
        .REFRESH_DIV  (4),
        .BLINK_FRAMES (2),
        .ACTIVE_LOW   (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .value_in   (value_in),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .lzb_en     (lzb_en),
        .blink_en   (blink_en),
        .load       (load),
        .seg        (seg),
        .dp         (dp),
        .anode      (anode),
        .frame_done (frame_done)
    );

    // Leaves reset low at a falling edge; the next falling edge is cycle k=1.
    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        load  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int         d;
        logic [3:0] exp_an;
        logic       exp_fd;
        value_in = '0; dp_in = '0; digit_en = 4'b1111;
        lzb_en = 1'b0; blink_en = 1'b0; load = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (anode !== 4'b1111) begin errors++; $display("FAIL reset_anode got %b want %b", anode, 4'b1111); end
        checks++;
        if (seg !== LBLANK) begin errors++; $display("FAIL reset_seg got %b want %b", seg, LBLANK); end
        checks++;
        if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got %b want 1", dp); end
        checks++;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
        reset = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            d = ((k - 1) / 4) % 4;
            exp_an = 4'b1111;
            exp_an[d] = 1'b0;
            exp_fd = (k % 16 == 0);
            checks++;
            if (anode !== exp_an) begin errors++; $display("FAIL scan_anode k=%0d got %b want %b", k, anode, exp_an); end
            checks++;
            if (seg !== L0) begin errors++; $display("FAIL scan_seg k=%0d got %b want %b", k, seg, L0); end
            checks++;
            if (frame_done !== exp_fd) begin errors++; $display("FAIL scan_frame_done k=%0d got %b want %b", k, frame_done, exp_fd); end
        end
    endtask

    task automatic test_load();
        int         d;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic [6:0] tbl [4];
        tbl = '{L5, L9, LC, L3};
        value_in = '0; dp_in = '0; digit_en = 4'b1111;
        lzb_en = 1'b0; blink_en = 1'b0;
        apply_reset();
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            d = ((k - 1) / 4) % 4;
            exp_an = 4'b1111;
            exp_an[d] = 1'b0;
            exp_seg = (k <= 16) ? L0 : tbl[d];
            checks++;
            if (anode !== exp_an) begin errors++; $display("FAIL load_anode k=%0d got %b want %b", k, anode, exp_an); end
            checks++;
            if (seg !== exp_seg) begin errors++; $display("FAIL load_seg k=%0d got %b want %b", k, seg, exp_seg); end
            if (k == 6) begin value_in = 16'h3C95; load = 1'b1; end
            if (k == 7) load = 1'b0;
        end
    endtask

    task automatic test_lzb();
        int         d;
        logic [6:0] exp_seg;
        logic       exp_dp;
        logic [6:0] tbl0 [4];
        logic [6:0] tbl1 [4];
        tbl0 = '{L0, LBLANK, LBLANK, LBLANK};
        tbl1 = '{L0, L5, LBLANK, LBLANK};
        value_in = 16'h0050; dp_in = 4'b1000; digit_en = 4'b1111;
        lzb_en = 1'b1; blink_en = 1'b0;
        apply_reset();
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            d = ((k - 1) / 4) % 4;
            exp_seg = (k <= 16) ? tbl0[d] : tbl1[d];
            exp_dp  = !((k > 16) && (d == 3));
            checks++;
            if (seg !== exp_seg) begin errors++; $display("FAIL lzb_seg k=%0d got %b want %b", k, seg, exp_seg); end
            checks++;
            if (dp !== exp_dp) begin errors++; $display("FAIL lzb_dp k=%0d got %b want %b", k, dp, exp_dp); end
            if (k == 1) load = 1'b1;
            if (k == 2) load = 1'b0;
        end
        lzb_en = 1'b0;
        dp_in = '0;
    endtask

    task automatic test_enable_blink();
        int         d;
        int         f;
        logic       off;
        logic [3:0] exp_an;
        logic [3:0] en_mask;
        en_mask = 4'b0101;
        value_in = '0; dp_in = '0; digit_en = en_mask;
        lzb_en = 1'b0; blink_en = 1'b1;
        apply_reset();
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            d = ((k - 1) / 4) % 4;
            f = (k - 1) / 16;
            off = ((f / 2) % 2) == 1;
            exp_an = 4'b1111;
            if (!off && en_mask[d]) exp_an[d] = 1'b0;
            checks++;
            if (anode !== exp_an) begin errors++; $display("FAIL blink_anode k=%0d got %b want %b", k, anode, exp_an); end
            checks++;
            if (frame_done !== (k % 16 == 0)) begin errors++; $display("FAIL blink_frame_done k=%0d got %b", k, frame_done); end
        end
        digit_en = 4'b1111;
        blink_en = 1'b0;
    endtask

    task automatic test_boundary_reset();
        int         d;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        value_in = '0; dp_in = '0; digit_en = 4'b1111;
        lzb_en = 1'b0; blink_en = 1'b0;
        apply_reset();
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            exp_seg = (k <= 32) ? L0 : L1;
            checks++;
            if (seg !== exp_seg) begin errors++; $display("FAIL boundary_seg k=%0d got %b want %b", k, seg, exp_seg); end
            if (k == 15) begin value_in = 16'h1111; load = 1'b1; end
            if (k == 16) load = 1'b0;
        end
        value_in = 16'h2222;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (anode !== 4'b1111) begin errors++; $display("FAIL midreset_anode got %b want %b", anode, 4'b1111); end
        checks++;
        if (seg !== LBLANK) begin errors++; $display("FAIL midreset_seg got %b want %b", seg, LBLANK); end
        checks++;
        if (dp !== 1'b1) begin errors++; $display("FAIL midreset_dp got %b want 1", dp); end
        checks++;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL midreset_frame_done got %b want 0", frame_done); end
        reset = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            d = ((k - 1) / 4) % 4;
            exp_an = 4'b1111;
            exp_an[d] = 1'b0;
            checks++;
            if (anode !== exp_an) begin errors++; $display("FAIL postreset_anode k=%0d got %b want %b", k, anode, exp_an); end
            checks++;
            if (seg !== L0) begin errors++; $display("FAIL postreset_seg k=%0d got %b want %b", k, seg, L0); end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_lzb();
        test_enable_blink();
        test_boundary_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
